// File: rtl/if_id_latch.sv
// -----------------------------------------------------------------------------
// if_id_latch
//
// IF/ID pipeline boundary for the 16-bit pipelined core. It captures the
// fetched instruction and its PC+2 from the fetch stage and holds them for
// decode. It also handles decode stalls, branch flushes, squashing of an
// instruction-memory fetch that belongs to a flushed path, and the HALT freeze.
//
// Handshake: fetch offers a beat (instr_in/pc2_in) whenever fetch_valid is
// high. The beat is consumed on the rising edge of a cycle in which
// fetch_ready is high. fetch_ready is also high during a flush, so that fetch
// redirects its PC. Beats offered while fetch_ready is low are not consumed.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-high reset
//   instr_in     in   [15:0] instruction from instruction memory
//   pc2_in       in   [15:0] PC+2 of instr_in
//   fetch_valid  in   instr_in/pc2_in valid this cycle (0 = memory busy/miss)
//   stall        in   decode hazard; hold IF/ID contents
//   flush        in   taken branch/jump resolved; discard younger instructions
//   instr_out    out  [15:0] latched instruction to decode
//   pc2_out      out  [15:0] latched PC+2
//   valid_out    out  latched instruction is real (0 = bubble)
//   fetch_ready  out  combinational; fetch may advance PC this cycle
//   halted       out  HALT captured and not yet flushed
//   dbg_state_o  out  [1:0] current FSM state (0 RUN, 1 SQUASH, 2 HALTED)
// -----------------------------------------------------------------------------
module if_id_latch #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc2_in,
    input  logic        fetch_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic [15:0] pc2_out,
    output logic        valid_out,
    output logic        fetch_ready,
    output logic        halted,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Datapath action selected by the FSM each cycle.
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_LOAD   = 2'd2
    } act_t;

    state_t      state_q, state_d;
    act_t        act;
    logic        halted_q, halted_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic        is_halt;

    assign is_halt = (instr_in[15:11] == HALT_OPC);

    // -------------------------------------------------------------------------
    // Next-state and action selection
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        act      = ACT_HOLD;

        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    act = ACT_BUBBLE;
                    // With no beat this cycle, the fetch in flight is from
                    // the wrong path and must be dropped when it lands.
                    state_d = fetch_valid ? ST_RUN : ST_SQUASH;
                end else if (stall) begin
                    act = ACT_HOLD;
                end else if (fetch_valid) begin
                    act = ACT_LOAD;
                    if (is_halt) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end
                end else begin
                    act = ACT_BUBBLE;
                end
            end

            ST_SQUASH: begin
                if (flush) begin
                    act = ACT_BUBBLE;
                end else begin
                    act = stall ? ACT_HOLD : ACT_BUBBLE;
                    // The stale beat arrives and is discarded even under stall.
                    if (fetch_valid) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_HALTED: begin
                if (flush) begin
                    act      = ACT_BUBBLE;
                    halted_d = 1'b0;
                    state_d  = fetch_valid ? ST_RUN : ST_SQUASH;
                end else if (stall) begin
                    act = ACT_HOLD;
                end else begin
                    act = ACT_BUBBLE;
                end
            end

            default: begin
                act      = ACT_BUBBLE;
                halted_d = 1'b0;
                state_d  = ST_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next values: enable-gated registers
    // -------------------------------------------------------------------------
    always_comb begin
        instr_d = instr_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;

        case (act)
            ACT_LOAD: begin
                instr_d = instr_in;
                pc2_d   = pc2_in;
                valid_d = 1'b1;
            end
            ACT_BUBBLE: begin
                // pc2 is left alone so decode still sees the last real PC+2.
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            instr_q  <= NOP_INSTR;
            pc2_q    <= 16'h0000;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            instr_q  <= instr_d;
            pc2_q    <= pc2_d;
            valid_q  <= valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // A flush always lets fetch advance so it can redirect to the target.
    assign fetch_ready = flush |
                         ((state_q == ST_RUN) & ~stall & fetch_valid & ~is_halt);

    assign instr_out   = instr_q;
    assign pc2_out     = pc2_q;
    assign valid_out   = valid_q;
    assign halted      = halted_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_if_id_latch.sv
// -----------------------------------------------------------------------------
// tb_if_id_latch
//
// Directed-vector bench for if_id_latch. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 time unit after the edge, and the
// combinational fetch_ready is sampled just before the edge.
// -----------------------------------------------------------------------------
module tb_if_id_latch;

    localparam logic [15:0] NOP = 16'h0800;

    // ---------------------------------------------------------------- clock/reset
    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic [15:0] pc2_in;
    logic        fetch_valid;
    logic        stall;
    logic        flush;
    logic [15:0] instr_out;
    logic [15:0] pc2_out;
    logic        valid_out;
    logic        fetch_ready;
    logic        halted;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    if_id_latch dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .pc2_in      (pc2_in),
        .fetch_valid (fetch_valid),
        .stall       (stall),
        .flush       (flush),
        .instr_out   (instr_out),
        .pc2_out     (pc2_out),
        .valid_out   (valid_out),
        .fetch_ready (fetch_ready),
        .halted      (halted),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------------------------------------------------------- checker
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic drive(input logic r, input logic fv, input logic [15:0] ins,
                         input logic [15:0] pc, input logic st, input logic fl);
        rst         = r;
        fetch_valid = fv;
        instr_in    = ins;
        pc2_in      = pc;
        stall       = st;
        flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample the combinational ready shortly before the coming edge.
    task automatic check_ready(input string tag, input logic exp);
        #2;
        check(tag, {15'd0, fetch_ready}, {15'd0, exp});
    endtask

    task automatic check_out(input string tag, input logic [15:0] ins,
                             input logic [15:0] pc, input logic v);
        check({tag, ".instr"}, instr_out, ins);
        check({tag, ".pc2"}, pc2_out, pc);
        check({tag, ".valid"}, {15'd0, valid_out}, {15'd0, v});
    endtask

    task automatic check_ctl(input string tag, input logic h, input logic [1:0] st);
        check({tag, ".halted"}, {15'd0, halted}, {15'd0, h});
        check({tag, ".state"}, {14'd0, dbg_state_o}, {14'd0, st});
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        check_out("reset", NOP, 16'h0000, 1'b0);
        check_ctl("reset", 1'b0, 2'd0);

        // Single load, then an idle cycle bubbles.
        drive(1'b0, 1'b1, 16'h4123, 16'h0002, 1'b0, 1'b0);
        check_ready("load1.ready", 1'b1);
        tick();
        check_out("load1", 16'h4123, 16'h0002, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        check_out("idle1", NOP, 16'h0002, 1'b0);

        // Load then stall for three cycles with new beats offered.
        drive(1'b0, 1'b1, 16'hC001, 16'h0010, 1'b0, 1'b0);
        tick();
        check_out("loadc001", 16'hC001, 16'h0010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 16'h1111 * 16'(i + 1), 16'h0012 + 16'(2 * i), 1'b1, 1'b0);
            check_ready("stall.ready", 1'b0);
            tick();
            check_out("stall", 16'hC001, 16'h0010, 1'b1);
        end

        // Flush with no beat -> squash the beat that lands later.
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check_ready("flush.ready", 1'b1);
        tick();
        check_out("flush", NOP, 16'h0010, 1'b0);
        check_ctl("flush", 1'b0, 2'd1);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check_ready("squash_wait.ready", 1'b0);
        tick();
        check_ctl("squash_wait", 1'b0, 2'd1);
        drive(1'b0, 1'b1, 16'hDEAD, 16'h0099, 1'b0, 1'b0);
        check_ready("dead.ready", 1'b0);
        tick();
        check_out("dead_dropped", NOP, 16'h0010, 1'b0);
        check_ctl("dead_dropped", 1'b0, 2'd0);
        drive(1'b0, 1'b1, 16'h4444, 16'h0020, 1'b0, 1'b0);
        tick();
        check_out("load4444", 16'h4444, 16'h0020, 1'b1);

        // HALT freeze and release by flush.
        drive(1'b0, 1'b1, 16'h0000, 16'h0030, 1'b0, 1'b0);
        check_ready("halt.ready", 1'b0);
        tick();
        check_out("halt", 16'h0000, 16'h0030, 1'b1);
        check_ctl("halt", 1'b1, 2'd2);
        drive(1'b0, 1'b1, 16'h4555, 16'h0032, 1'b0, 1'b0);
        check_ready("halted.ready", 1'b0);
        tick();
        check_out("halted_bubble", NOP, 16'h0030, 1'b0);
        check_ctl("halted_bubble", 1'b1, 2'd2);
        drive(1'b0, 1'b1, 16'h4555, 16'h0032, 1'b0, 1'b1);
        check_ready("unhalt.ready", 1'b1);
        tick();
        check_out("unhalt", NOP, 16'h0030, 1'b0);
        check_ctl("unhalt", 1'b0, 2'd0);
        drive(1'b0, 1'b1, 16'h4666, 16'h0040, 1'b0, 1'b0);
        tick();
        check_out("load4666", 16'h4666, 16'h0040, 1'b1);

        // Reset while in SQUASH, with stall/flush/beat also present.
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tick();
        check_ctl("to_squash", 1'b0, 2'd1);
        drive(1'b1, 1'b1, 16'h4777, 16'h0050, 1'b1, 1'b1);
        tick();
        check_out("rst_squash", NOP, 16'h0000, 1'b0);
        check_ctl("rst_squash", 1'b0, 2'd0);

        // Reset while in HALTED.
        drive(1'b0, 1'b1, 16'h0000, 16'h0060, 1'b0, 1'b0);
        tick();
        check_ctl("to_halted", 1'b1, 2'd2);
        drive(1'b1, 1'b1, 16'h4888, 16'h0062, 1'b1, 1'b1);
        tick();
        check_out("rst_halted", NOP, 16'h0000, 1'b0);
        check_ctl("rst_halted", 1'b0, 2'd0);

        // Same-cycle flush + stall + beat in RUN.
        drive(1'b0, 1'b1, 16'h4999, 16'h0070, 1'b0, 1'b0);
        tick();
        check_out("load4999", 16'h4999, 16'h0070, 1'b1);
        drive(1'b0, 1'b1, 16'h1234, 16'h0072, 1'b1, 1'b1);
        check_ready("fsf.ready", 1'b1);
        tick();
        check_out("fsf", NOP, 16'h0070, 1'b0);
        check_ctl("fsf", 1'b0, 2'd0);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        check_out("fsf_after", NOP, 16'h0070, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_latch.md
Name: if_id_latch

Overview:
- IF/ID pipeline boundary for the 16-bit pipelined core.
- Captures the fetched instruction and PC+2 from the fetch stage and holds them for decode.
- Handles hazard stalls, branch flushes, squashing of an outstanding instruction-memory fetch, and HALT freeze.
- Data storage is built from enable-gated 16-bit registers. Sequencing is a 3-state FSM.

Parameters:
- NOP_INSTR, 16'h0800, encoding injected as a bubble.
- HALT_OPC, 5'b00000, opcode in instr_in[15:11] that marks HALT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_in  in  16  instruction from instruction memory.
- pc2_in  in  16  PC+2 of instr_in.
- fetch_valid  in  1  instr_in/pc2_in valid this cycle (0 = memory busy/miss).
- stall  in  1  decode hazard; hold IF/ID contents.
- flush  in  1  taken branch/jump resolved; discard younger instructions.
- instr_out  out  16  latched instruction to decode.
- pc2_out  out  16  latched PC+2.
- valid_out  out  1  latched instruction is real (0 = bubble).
- fetch_ready  out  1  combinational; fetch may advance PC this cycle.
- halted  out  1  HALT captured and not yet flushed.

Behaviour:
- Reset: one rst=1 edge sets state=RUN, instr_out=NOP_INSTR, pc2_out=0, valid_out=0, halted=0. Reset overrides every other input, including mid-squash or mid-halt.
- Priority each edge: rst > flush > stall > normal load.
- Load means instr_out<=instr_in, pc2_out<=pc2_in, valid_out<=1.
- Bubble means instr_out<=NOP_INSTR, valid_out<=0, pc2_out held.
- Hold means all outputs are unchanged.
- State RUN:
  - flush: bubble. If fetch_valid=0, go to SQUASH; otherwise stay in RUN (the arriving beat is dropped).
  - stall (no flush): hold; stay in RUN.
  - fetch_valid=1 and instr_in[15:11]!=HALT_OPC: load; stay in RUN.
  - fetch_valid=1 and instr_in[15:11]==HALT_OPC: load; go to HALTED; halted<=1.
  - fetch_valid=0: bubble; stay in RUN.
- State SQUASH (an outstanding fetch belongs to the flushed path):
  - fetch_valid=1: drop the beat, regardless of stall. Bubble if stall=0, hold if stall=1. Go to RUN.
  - fetch_valid=0: bubble if stall=0, hold if stall=1; stay in SQUASH.
  - flush: bubble; stay in SQUASH.
- State HALTED:
  - flush: bubble; halted<=0. Next state is SQUASH if fetch_valid=0, RUN otherwise.
  - stall: hold.
  - otherwise: bubble.
  - fetch_valid is ignored.
- fetch_ready = (state==RUN) & ~stall & ~flush & fetch_valid & (instr_in[15:11]!=HALT_OPC).
- fetch_ready is also asserted when flush=1, so fetch redirects.
- fetch_ready is 0 while in SQUASH or HALTED without flush.
- Latency: a beat accepted at edge N appears on instr_out after edge N. There is no combinational path from instr_in to instr_out.
- A flush and a fetch_valid beat in the same cycle: the beat is never loaded.

Test Plan:
- Reset, then fetch_valid=1 with instr 16'h4123, pc2 16'h0002 for 1 cycle -> after 1 edge: instr_out=16'h4123, pc2_out=16'h0002, valid_out=1. The next idle cycle (fetch_valid=0) gives instr_out=16'h0800, valid_out=0.
- Load 16'hC001, then stall=1 for 3 cycles with new beats on instr_in -> instr_out stays 16'hC001 with valid_out=1, and fetch_ready=0 throughout.
- Flush with fetch_valid=0, then fetch_valid=1 with 16'hDEAD two cycles later, then 16'h4444 -> 16'hDEAD is never on instr_out, and 16'h4444 loads (valid_out=1) on the following edge.
- Fetch HALT 16'h0000 -> halted=1, valid_out=1 for 1 cycle then bubble. fetch_ready=0 with further beats applied. A later flush makes halted=0, and the next beat loads.
- Assert rst while in SQUASH and while in HALTED, with stall=1 and flush=1 also set -> after 1 edge: state RUN, instr_out=16'h0800, pc2_out=0, valid_out=0, halted=0.
- Same-cycle flush + stall + fetch_valid=1 (16'h1234) in RUN -> bubble, state remains RUN, and 16'h1234 is never latched.
